// File: rtl/cpu_execute_muldiv_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
interface cpu_execute_muldiv_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned TAG_WIDTH = 8
);
  logic                 i_valid;
  logic                 i_stall;
  logic [TAG_WIDTH-1:0] i_tag;
  logic [2:0]           i_op;
  logic [XLEN-1:0]      i_rs1;
  logic [XLEN-1:0]      i_rs2;
  logic                 o_busy;
  logic                 o_done;
  logic [TAG_WIDTH-1:0] o_tag;
  logic [XLEN-1:0]      o_rd;

  modport master (
    output i_valid, i_stall, i_tag, i_op, i_rs1, i_rs2,
    input  o_busy, o_done, o_tag, o_rd
  );

  modport slave (
    input  i_valid, i_stall, i_tag, i_op, i_rs1, i_rs2,
    output o_busy, o_done, o_tag, o_rd
  );
endinterface

// File: rtl/cpu_execute_muldiv.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: counted-latency multiply and
// iterative radix-2^RADIX_BITS restoring divide, tagged result.
module cpu_execute_muldiv #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RADIX_BITS = 1,
  parameter int unsigned MUL_STAGES = 2,
  parameter int unsigned TAG_WIDTH  = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  cpu_execute_muldiv_if.slave  io_bus
);

  localparam int unsigned DIV_ITERS = XLEN / RADIX_BITS;
  localparam int unsigned CNT_W     = $clog2(DIV_ITERS + MUL_STAGES + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t               r_state;
  logic [1:0]           r_op;
  logic [TAG_WIDTH-1:0] r_tag;
  logic [CNT_W-1:0]     r_cnt;
  logic [XLEN-1:0]      r_a;
  logic [XLEN-1:0]      r_b;
  logic [XLEN-1:0]      r_quot;
  logic [XLEN-1:0]      r_rem;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_done;
  logic [TAG_WIDTH-1:0] r_tag_out;
  logic [XLEN-1:0]      r_rd;

  logic                 w_new_tag;
  logic                 w_accept;
  logic                 w_div_signed;
  logic                 w_s1;
  logic                 w_s2;
  logic [XLEN-1:0]      w_abs1;
  logic [XLEN-1:0]      w_abs2;
  logic [XLEN-1:0]      w_min_neg;
  logic                 w_div_zero;
  logic                 w_div_ovf;
  logic                 w_a_sx;
  logic                 w_b_sx;
  logic [2*XLEN-1:0]    w_a_ext;
  logic [2*XLEN-1:0]    w_b_ext;
  logic [2*XLEN-1:0]    w_prod;
  logic [XLEN-1:0]      w_mul_res;
  logic [XLEN:0]        w_part;
  logic [XLEN-1:0]      w_rem_n;
  logic [XLEN-1:0]      w_quot_n;
  logic [XLEN-1:0]      w_q_fix;
  logic [XLEN-1:0]      w_r_fix;
  logic [XLEN-1:0]      w_div_res;

  assign w_new_tag      = io_bus.i_tag != r_tag_out;
  assign w_accept       = (r_state == S_IDLE) && io_bus.i_valid && !io_bus.i_stall && w_new_tag;
  assign io_bus.o_busy  = io_bus.i_stall | (io_bus.i_valid & w_new_tag);
  assign io_bus.o_done  = r_done;
  assign io_bus.o_tag   = r_tag_out;
  assign io_bus.o_rd    = r_rd;

  // Divide operand conditioning happens on the raw inputs at acceptance
  assign w_div_signed = ~io_bus.i_op[0];
  assign w_s1         = w_div_signed & io_bus.i_rs1[XLEN-1];
  assign w_s2         = w_div_signed & io_bus.i_rs2[XLEN-1];
  assign w_abs1       = w_s1 ? -io_bus.i_rs1 : io_bus.i_rs1;
  assign w_abs2       = w_s2 ? -io_bus.i_rs2 : io_bus.i_rs2;
  assign w_min_neg    = {1'b1, {(XLEN-1){1'b0}}};
  assign w_div_zero   = io_bus.i_rs2 == '0;
  assign w_div_ovf    = w_div_signed && (io_bus.i_rs1 == w_min_neg) && (io_bus.i_rs2 == '1);

  // rs1 signed for MUL/MULH/MULHSU, rs2 signed for MUL/MULH
  assign w_a_sx    = (r_op != 2'd3) & r_a[XLEN-1];
  assign w_b_sx    = ~r_op[1] & r_b[XLEN-1];
  assign w_a_ext   = {{XLEN{w_a_sx}}, r_a};
  assign w_b_ext   = {{XLEN{w_b_sx}}, r_b};
  assign w_prod    = w_a_ext * w_b_ext;
  assign w_mul_res = (r_op == 2'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // RADIX_BITS restoring steps per cycle; partial remainder needs XLEN+1 bits
  always_comb begin
    w_rem_n  = r_rem;
    w_quot_n = r_quot;
    w_part   = '0;
    for (int unsigned k = 0; k < RADIX_BITS; k++) begin
      w_part   = {w_rem_n, w_quot_n[XLEN-1]};
      w_quot_n = {w_quot_n[XLEN-2:0], 1'b0};
      if (w_part >= {1'b0, r_b}) begin
        w_part      = w_part - {1'b0, r_b};
        w_quot_n[0] = 1'b1;
      end
      w_rem_n = w_part[XLEN-1:0];
    end
  end

  assign w_q_fix   = r_neg_q ? -r_quot : r_quot;
  assign w_r_fix   = r_neg_r ? -r_rem : r_rem;
  assign w_div_res = r_op[1] ? w_r_fix : w_q_fix;

  // Control FSM: accept, count multiply latency or iterate divide, publish result
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_tag     <= '0;
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_done    <= 1'b0;
      r_tag_out <= '0;
      r_rd      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op  <= io_bus.i_op[1:0];
            r_tag <= io_bus.i_tag;
            if (!io_bus.i_op[2]) begin
              r_a     <= io_bus.i_rs1;
              r_b     <= io_bus.i_rs2;
              r_cnt   <= CNT_W'(MUL_STAGES - 1);
              r_state <= S_MUL;
            end else if (w_div_zero) begin
              r_quot  <= '1;
              r_rem   <= io_bus.i_rs1;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_state <= S_FIX;
            end else if (w_div_ovf) begin
              r_quot  <= io_bus.i_rs1;
              r_rem   <= '0;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_state <= S_FIX;
            end else begin
              r_quot  <= w_abs1;
              r_rem   <= '0;
              r_b     <= w_abs2;
              r_neg_q <= w_s1 ^ w_s2;
              r_neg_r <= w_s1;
              r_cnt   <= CNT_W'(DIV_ITERS - 1);
              r_state <= S_DIV;
            end
          end
        end
        S_MUL: begin
          if (r_cnt == '0) begin
            r_rd      <= w_mul_res;
            r_tag_out <= r_tag;
            r_done    <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DIV: begin
          r_quot <= w_quot_n;
          r_rem  <= w_rem_n;
          if (r_cnt == '0) r_state <= S_FIX;
          else             r_cnt   <= r_cnt - CNT_W'(1);
        end
        S_FIX: begin
          r_rd      <= w_div_res;
          r_tag_out <= r_tag;
          r_done    <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_execute_muldiv.sv
// Directed self-checking bench for cpu_execute_muldiv: base build (32/1/2),
// radix-4 divide build and 64-bit build.
module tb_cpu_execute_muldiv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] cur_tag = 8'd0;

  always #5 clk = ~clk;

  cpu_execute_muldiv_if #(.XLEN(32), .TAG_WIDTH(8)) bm ();
  cpu_execute_muldiv_if #(.XLEN(32), .TAG_WIDTH(8)) b4 ();
  cpu_execute_muldiv_if #(.XLEN(64), .TAG_WIDTH(8)) b64 ();

  cpu_execute_muldiv #(.XLEN(32), .RADIX_BITS(1), .MUL_STAGES(2), .TAG_WIDTH(8)) u_dut (
    .i_clock(clk), .i_reset(rst), .io_bus(bm.slave));
  cpu_execute_muldiv #(.XLEN(32), .RADIX_BITS(4), .MUL_STAGES(2), .TAG_WIDTH(8)) u_dut_r4 (
    .i_clock(clk), .i_reset(rst), .io_bus(b4.slave));
  cpu_execute_muldiv #(.XLEN(64), .RADIX_BITS(1), .MUL_STAGES(2), .TAG_WIDTH(8)) u_dut_x64 (
    .i_clock(clk), .i_reset(rst), .io_bus(b64.slave));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one op on the base build and check latency, result, tag and busy.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit stall_mid, input bit tag_flip);
    int seen;
    logic [7:0] tag;
    seen = 0;
    cur_tag++;
    tag = cur_tag;
    @(negedge clk);
    bm.i_valid = 1'b1; bm.i_stall = 1'b0; bm.i_op = op;
    bm.i_rs1 = a; bm.i_rs2 = b; bm.i_tag = tag;
    #1 check_eq({name, "_busy_pre"}, bm.o_busy, 1);
    @(posedge clk);
    for (int c = 1; c <= lat + 3 && seen == 0; c++) begin
      @(negedge clk);
      if (stall_mid && c == 5) bm.i_stall = 1'b1;
      if (tag_flip && c == 5) begin
        bm.i_tag = tag ^ 8'h55;
        bm.i_rs1 = ~a;
      end
      @(posedge clk);
      #1 if (bm.o_done) seen = c;
    end
    check_eq({name, "_lat"}, seen, lat);
    check_eq({name, "_rd"}, bm.o_rd, exp);
    check_eq({name, "_tag"}, bm.o_tag, tag);
    @(negedge clk);
    bm.i_tag = tag; bm.i_stall = 1'b0; bm.i_rs1 = a;
    #1 check_eq({name, "_busy_post"}, bm.o_busy, 0);
    @(posedge clk);
    #1 check_eq({name, "_single_pulse"}, bm.o_done, 0);
    @(negedge clk);
    bm.i_valid = 1'b0;
  endtask

  initial begin
    int seen;
    int dones;
    bm.i_valid = 0;  bm.i_stall = 0;  bm.i_tag = 0;  bm.i_op = 0;  bm.i_rs1 = 0;  bm.i_rs2 = 0;
    b4.i_valid = 0;  b4.i_stall = 0;  b4.i_tag = 0;  b4.i_op = 0;  b4.i_rs1 = 0;  b4.i_rs2 = 0;
    b64.i_valid = 0; b64.i_stall = 0; b64.i_tag = 0; b64.i_op = 0; b64.i_rs1 = 0; b64.i_rs2 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_tag", bm.o_tag, 0);
    check_eq("rst_rd", bm.o_rd, 0);
    check_eq("rst_done", bm.o_done, 0);
    check_eq("rst_busy", bm.o_busy, 0);

    // Multiply family
    run_op("mul",    3'd0, 32'h7FFFFFFF, 32'h00000002, 32'hFFFFFFFE, 2, 0, 0);
    run_op("mulh",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2, 0, 0);
    run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 2, 0, 0);
    run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, 0, 0);
    run_op("mul_neg", 3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 2, 0, 0);

    // Divide family, normal path
    run_op("div",    3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 0, 0);
    run_op("rem",    3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 0, 0);
    run_op("divu",   3'd5, 32'd100, 32'd7, 32'd14, 33, 0, 0);
    run_op("remu",   3'd7, 32'd100, 32'd7, 32'd2, 33, 0, 0);
    run_op("div_pn", 3'd4, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33, 0, 0);
    run_op("rem_pn", 3'd6, 32'd7, 32'hFFFFFFFE, 32'd1, 33, 0, 0);
    run_op("divu_big", 3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33, 0, 0);
    run_op("remu_big", 3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 0, 0);

    // Special cases
    run_op("div_z",   3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 0, 0);
    run_op("rem_z",   3'd6, 32'd5, 32'd0, 32'd5, 1, 0, 0);
    run_op("divu_z",  3'd5, 32'd7, 32'd0, 32'hFFFFFFFF, 1, 0, 0);
    run_op("remu_z",  3'd7, 32'd7, 32'd0, 32'd7, 1, 0, 0);
    run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, 0);
    run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 0, 0);

    // Mid-operation stall and tag/operand changes are ignored
    run_op("divu_stall", 3'd5, 32'd100, 32'd7, 32'd14, 33, 1, 0);
    run_op("div_tagflip", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 0, 1);

    // Stall held with a new tag blocks acceptance
    cur_tag++;
    @(negedge clk);
    bm.i_valid = 1'b1; bm.i_stall = 1'b1; bm.i_op = 3'd0;
    bm.i_rs1 = 32'd3; bm.i_rs2 = 32'd3; bm.i_tag = cur_tag;
    dones = 0;
    repeat (4) begin
      @(posedge clk);
      #1 if (bm.o_done) dones++;
    end
    check_eq("stall_busy", bm.o_busy, 1);
    check_eq("stall_no_done", dones, 0);
    check_eq("stall_tag_kept", bm.o_tag, cur_tag - 8'd1);
    @(negedge clk);
    bm.i_valid = 1'b0; bm.i_stall = 1'b0;

    // Reset in the middle of a divide abandons it
    cur_tag++;
    @(negedge clk);
    bm.i_valid = 1'b1; bm.i_op = 3'd4; bm.i_rs1 = 32'hFFFFFFF9; bm.i_rs2 = 32'd2; bm.i_tag = cur_tag;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; bm.i_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst_tag", bm.o_tag, 0);
    check_eq("midrst_rd", bm.o_rd, 0);
    check_eq("midrst_done", bm.o_done, 0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (bm.o_done) dones++;
    end
    check_eq("midrst_no_done", dones, 0);
    run_op("post_rst_divu", 3'd5, 32'd100, 32'd7, 32'd14, 33, 0, 0);

    // Radix-4 build
    @(negedge clk);
    b4.i_valid = 1'b1; b4.i_op = 3'd5; b4.i_rs1 = 32'hFFFFFFFF; b4.i_rs2 = 32'd3; b4.i_tag = 8'h01;
    @(posedge clk);
    seen = 0;
    for (int c = 1; c <= 20 && seen == 0; c++) begin
      @(posedge clk);
      #1 if (b4.o_done) seen = c;
    end
    check_eq("r4_divu_lat", seen, 9);
    check_eq("r4_divu_rd", b4.o_rd, 32'h55555555);
    check_eq("r4_divu_tag", b4.o_tag, 8'h01);
    @(negedge clk);
    b4.i_op = 3'd6; b4.i_rs1 = 32'hFFFFFFF9; b4.i_rs2 = 32'd2; b4.i_tag = 8'h02;
    @(posedge clk);
    seen = 0;
    for (int c = 1; c <= 20 && seen == 0; c++) begin
      @(posedge clk);
      #1 if (b4.o_done) seen = c;
    end
    check_eq("r4_rem_lat", seen, 9);
    check_eq("r4_rem_rd", b4.o_rd, 32'hFFFFFFFF);
    @(negedge clk);
    b4.i_valid = 1'b0;

    // 64-bit build
    @(negedge clk);
    b64.i_valid = 1'b1; b64.i_op = 3'd3; b64.i_rs1 = '1; b64.i_rs2 = '1; b64.i_tag = 8'h01;
    @(posedge clk);
    seen = 0;
    for (int c = 1; c <= 10 && seen == 0; c++) begin
      @(posedge clk);
      #1 if (b64.o_done) seen = c;
    end
    check_eq("x64_mulhu_lat", seen, 2);
    check_eq("x64_mulhu_rd", b64.o_rd, 64'hFFFFFFFFFFFFFFFE);
    check_eq("x64_mulhu_tag", b64.o_tag, 8'h01);
    @(negedge clk);
    b64.i_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_execute_muldiv.md
# cpu_execute_muldiv

Parametrised multi-cycle multiply/divide unit for the execute stage, replacing the fixed-latency 32-bit multiplier/divider pair used by complex ops. It accepts one RV32M/RV64M-style operation per tag change, computes multiply in a configurable pipeline and divide with an iterative radix-2^RADIX_BITS restoring divider, and returns a tagged result. Signed, unsigned and mixed-sign variants, divide-by-zero and signed overflow follow RISC-V M semantics.

## Interface
- XLEN, 32, operand/result width; multiple of RADIX_BITS, ≥ 8
- RADIX_BITS, 1, quotient bits retired per divide cycle; legal 1, 2, 4
- MUL_STAGES, 2, multiply latency in cycles; ≥ 1
- TAG_WIDTH, 8, width of issue tag
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  current execute op targets this unit
- i_stall  in  1  downstream (memory) busy; blocks acceptance only
- i_tag  in  TAG_WIDTH  issue tag; new op when ≠ o_tag
- i_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- i_rs1  in  XLEN  operand 1 (dividend / multiplicand)
- i_rs2  in  XLEN  operand 2 (divisor / multiplier)
- o_busy  out  1  combinational: i_stall | (i_valid & i_tag ≠ o_tag)
- o_done  out  1  one-cycle pulse when o_rd/o_tag update
- o_tag  out  TAG_WIDTH  tag of last completed op
- o_rd  out  XLEN  result of last completed op

## Operation
- States: IDLE, MUL, DIV, FIX.
- Accept in IDLE when i_valid & !i_stall & i_tag ≠ o_tag: latch i_op, i_rs1, i_rs2, i_tag. Inputs are not sampled again until next IDLE.
- MUL family: 2·XLEN product of sign/zero-extended operands (rs1 signed for MUL/MULH/MULHSU; rs2 signed for MUL/MULH). MUL returns low XLEN bits, others high XLEN bits. Counter of MUL_STAGES cycles, then complete.
- DIV family, special cases resolved at accept, transition straight to FIX with result preset:
  - divisor 0: quotient all-ones, remainder = dividend (both signed and unsigned).
  - signed, dividend = most-negative, divisor = −1: quotient = dividend, remainder 0.
- Otherwise: take absolute values for signed ops, record result signs (quotient: sign1^sign2; remainder: sign of dividend). DIV iterates XLEN/RADIX_BITS cycles, each shifting RADIX_BITS dividend bits into the partial remainder and performing RADIX_BITS restoring subtract steps. FIX applies two's-complement negation as recorded and selects quotient or remainder.
- Completion (end of MUL count or FIX): o_rd ← result, o_tag ← latched tag, o_done ← 1, return to IDLE.
- i_tag / i_rs changes while not IDLE are ignored; i_stall mid-operation does not pause computation.
- o_busy stays high through completion cycle edge; low the cycle after o_tag matches i_tag (absent stall).

## Timing
- Reset: state IDLE, o_tag 0, o_rd 0, o_done 0, counters 0. Reset mid-operation abandons it; no completion is produced.
- Acceptance edge = E0. o_done high, o_rd/o_tag valid after edge:
  - MUL family: E0 + MUL_STAGES.
  - DIV normal: E0 + XLEN/RADIX_BITS + 1 (iterations + FIX).
  - DIV special case: E0 + 1.
- Back-to-back: next op accepted no earlier than the edge after completion (one IDLE cycle); throughput one op per latency+1.
- Width rules: all internal arithmetic at XLEN+1 bits for remainder, 2·XLEN for product; no truncation before final select.

## Test plan
- XLEN=32, RADIX_BITS=1, MUL_STAGES=2: MUL 0x7FFFFFFF×2 → o_rd 0xFFFFFFFE at E0+2; MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000; MULHU same → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD, REM −7/2 → 0xFFFFFFFF, DIVU 100/7 → 14, REMU → 2; each completes at E0+33 with single o_done pulse.
- DIV 5/0 → 0xFFFFFFFF, REM 5/0 → 5, DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0; each at E0+1.
- RADIX_BITS=4 build: DIVU 0xFFFFFFFF/3 → 0x55555555 at E0+9; XLEN=64 build: MULHU (2^64−1)² → 0xFFFFFFFFFFFFFFFE.
- i_stall held high with new tag → no acceptance, o_busy 1; stall raised mid-DIV → completion still at E0+33; i_tag toggled mid-DIV → o_tag equals tag latched at E0.
- Reset asserted at E0+10 of a DIV → o_tag 0, o_rd 0, no o_done; new op accepted cleanly after reset deasserts.
